square_share_ctrl: RTL and testbench



---
 rtl/square_pkg.sv | 40 ++++
 rtl/square_seq.sv | 55 +++++
 rtl/square_share_ctrl.sv | 122 ++++++++++++
 tb/tb_square_share_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/square_pkg.sv
// square_pkg
//   Shared definitions for the shared squarer controller.
//   - state_t        : controller FSM states (IDLE / CALC / DONE)
//   - DEF_WIDTH      : default operand width
//   - DEF_N_REQ      : default number of requesters
//   - MAX_REQ        : largest requester count the arbiter helper supports
//   - rr_next_grant  : round-robin winner search, returns {found, index}
package square_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N_REQ = 4;
   localparam int MAX_REQ   = 8;

   // Search starts one past the previous grant and wraps, so the most
   // recently served requester has the lowest priority next time.
   // Result bit 3 flags that a winner exists; bits 2:0 hold its index.
   function automatic logic [3:0] rr_next_grant(input logic [MAX_REQ-1:0] valid,
                                                input logic [2:0]         last,
                                                input int                 n_req);
      logic [3:0] result;
      int         idx;
      result = '0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         idx = int'(last) + k;
         // last < n_req and k <= n_req, so one wrap is always enough
         if (idx >= n_req) idx = idx - n_req;
         if ((k <= n_req) && !result[3] && valid[idx[2:0]]) begin
            result = {1'b1, idx[2:0]};
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/square_seq.sv
// square_seq
//   Multi-cycle shift-add squarer: one operand bit per step.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset (bit counter only)
//     i_start    in   load operand, clear accumulator and bit counter
//     i_opnd     in   operand to square (WIDTH bits)
//     i_step     in   process the current bit
//     o_acc_nxt  out  accumulator value after the current step (2*WIDTH bits)
//     o_last     out  current step handles the final operand bit
module square_seq
   import square_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_opnd,
   input  logic                 i_step,
   output logic [2*WIDTH-1:0]   o_acc_nxt,
   output logic                 o_last
);

   logic [WIDTH-1:0]   r_opnd;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] w_addend;

   // Partial product for the current bit: opnd weighted by 2^cnt.
   assign w_addend  = {{WIDTH{1'b0}}, r_opnd} << r_cnt;
   assign o_acc_nxt = r_opnd[r_cnt] ? (r_acc + w_addend) : r_acc;
   assign o_last    = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (i_start) begin
         r_opnd <= i_opnd;
         r_acc  <= '0;
      end else if (i_step) begin
         r_acc  <= o_acc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= '0;
      end else if (i_step) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/square_share_ctrl.sv
// square_share_ctrl
//   Round-robin front end sharing one shift-add squarer among N_REQ requesters.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset, overrides everything
//     req_valid  in   per-requester operand valid
//     req_data   in   operands, requester i at [i*WIDTH +: WIDTH]
//     req_ready  out  one-hot accept strobe, only in IDLE
//     res_valid  out  one-cycle result strobe
//     res_id     out  owner of res_data
//     res_data   out  square of the accepted operand (held between results)
//     busy       out  high in CALC and DONE
module square_share_ctrl
   import square_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   localparam int IDW  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   res_valid,
   output logic [IDW-1:0]         res_id,
   output logic [2*WIDTH-1:0]     res_data,
   output logic                   busy
);

   state_t             r_state;
   state_t             w_next_state;
   logic [IDW-1:0]     r_last_grant;
   logic [IDW-1:0]     r_tag;
   logic               r_res_valid;
   logic [IDW-1:0]     r_res_id;
   logic [2*WIDTH-1:0] r_res_data;

   logic [MAX_REQ-1:0] w_valid_ext;
   logic [3:0]         w_pick;
   logic               w_any;
   logic [IDW-1:0]     w_win;
   logic               w_start;
   logic               w_step;
   logic               w_last;
   logic [2*WIDTH-1:0] w_acc_nxt;

   assign w_valid_ext = MAX_REQ'(req_valid);
   assign w_pick      = rr_next_grant(w_valid_ext, 3'(r_last_grant), N_REQ);
   assign w_any       = w_pick[3];
   assign w_win       = IDW'(w_pick[2:0]);

   square_seq #(
      .WIDTH     (WIDTH)
   ) u_seq (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_opnd    (req_data[w_win*WIDTH +: WIDTH]),
      .i_step    (w_step),
      .o_acc_nxt (w_acc_nxt),
      .o_last    (w_last)
   );

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_step       = 1'b0;
      req_ready    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_start          = 1'b1;
               req_ready[w_win] = 1'b1;
               w_next_state     = ST_CALC;
            end
         end
         ST_CALC: begin
            w_step = 1'b1;
            if (w_last) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
      // A reset cycle accepts nothing, so the strobe must not claim otherwise.
      if (rst) req_ready = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= IDW'(N_REQ - 1);
         r_res_valid  <= 1'b0;
         r_res_id     <= '0;
         r_res_data   <= '0;
      end else begin
         r_state     <= w_next_state;
         r_res_valid <= (r_state == ST_CALC) && w_last;
         if (w_start) r_last_grant <= w_win;
         // Capture the final accumulator on the last step so the result
         // is visible during DONE rather than one cycle later.
         if ((r_state == ST_CALC) && w_last) begin
            r_res_data <= w_acc_nxt;
            r_res_id   <= r_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_start) r_tag <= w_win;
   end

   assign res_valid = r_res_valid;
   assign res_id    = r_res_id;
   assign res_data  = r_res_data;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_square_share_ctrl.sv
module tb_square_share_ctrl;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = 2;
   localparam int LAT = W + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           res_valid;
   logic [IDW-1:0] res_id;
   logic [2*W-1:0] res_data;
   logic           busy;

   square_share_ctrl #(
      .N_REQ     (N),
      .WIDTH     (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int val;
      int due;
   } exp_t;

   exp_t         sb[$];
   int           grant_log[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   bit           chk_en   = 1'b0;
   logic [N-1:0] tb_valid = '0;
   logic [N-1:0] acc_mask = '0;
   logic [W-1:0] tb_data[N];

   // reference model state: cycles left before the squarer is free again,
   // and the requester served most recently
   int m_busy = 0;
   int m_last = N - 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive();
      req_valid = tb_valid;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = tb_data[i];
   endtask

   // advance one cycle; requesters that were accepted drop their request
   task automatic tick();
      @(posedge clk);
      #1;
      tb_valid = tb_valid & ~acc_mask;
      drive();
   endtask

   task automatic wait_accept(input int i);
      int g;
      g = 0;
      while (tb_valid[i] && g < 100) begin
         tick();
         g++;
      end
      check("accept_timeout", 32'(g < 100), 1);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while ((tb_valid != '0 || busy || sb.size() != 0) && g < 400) begin
         tick();
         g++;
      end
      check("idle_timeout", 32'(g < 400), 1);
   endtask

   task automatic check_log(input string nm, input int exp_q[$]);
      check({nm, "_len"}, grant_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++) begin
         check(nm, grant_log[i], exp_q[i]);
      end
      grant_log.delete();
   endtask

   // checker: scoreboard monitor plus arbitration model, once per cycle
   initial begin
      exp_t         e;
      int           w;
      int           idx;
      int           op;
      logic [N-1:0] exp_ready;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (res_valid === 1'b1) begin
               if (sb.size() == 0) begin
                  check("res_unexpected", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("res_id", 32'(res_id), e.id);
                  check("res_data", 32'(res_data), e.val);
                  check("res_cycle", cyc, e.due);
               end
            end else if (sb.size() != 0 && cyc >= sb[0].due) begin
               check("res_missing", 32'(res_valid), 1);
               void'(sb.pop_front());
            end

            check("busy", 32'(busy), 32'(m_busy > 0));
            check("ready_while_busy", 32'(busy && (req_ready != '0)), 0);

            exp_ready = '0;
            w = -1;
            if (!rst && m_busy == 0) begin
               for (int k = 1; k <= N; k++) begin
                  idx = (m_last + k) % N;
                  if (w < 0 && req_valid[idx]) w = idx;
               end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_ready));

            for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
            acc_mask = req_ready;

            if (rst) begin
               m_busy = 0;
               m_last = N - 1;
               sb.delete();
            end else if (m_busy > 0) begin
               m_busy--;
            end else if (w >= 0) begin
               op     = int'(req_data[w*W +: W]);
               m_last = w;
               m_busy = LAT;
               sb.push_back('{w, op * op, cyc + LAT});
            end
         end
         cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      for (int i = 0; i < N; i++) tb_data[i] = '0;
      drive();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_id", 32'(res_id), 0);
      check("rst_res_data", 32'(res_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      chk_en = 1'b1;
      rst    = 1'b0;

      // all four at once, two rounds, order from reset is 0,1,2,3
      for (int round = 0; round < 2; round++) begin
         tb_data[0] = 8'd3; tb_data[1] = 8'd5; tb_data[2] = 8'd7; tb_data[3] = 8'd9;
         tb_valid = '1;
         drive();
         wait_idle();
         check_log("order_all4", '{0, 1, 2, 3});
      end

      // single request from 1: 221^2 = 48841
      tb_data[1] = 8'd221;
      tb_valid   = 4'b0010;
      drive();
      wait_idle();
      check_log("single", '{1});
      check("single_res_data", 32'(res_data), 48841);

      // boundary operands; last grant was 1 so order is 2,3,0,1
      tb_data[0] = 8'd0; tb_data[1] = 8'd255; tb_data[2] = 8'd128; tb_data[3] = 8'd1;
      tb_valid = '1;
      drive();
      wait_idle();
      check_log("order_bounds", '{2, 3, 0, 1});

      // fairness: grant 2, then 0 and 3 compete -> 3 before 0
      tb_data[2] = 8'd17;
      tb_valid   = 4'b0100;
      drive();
      wait_accept(2);
      tb_data[0] = 8'd44; tb_data[3] = 8'd99;
      tb_valid   = 4'b1001;
      drive();
      wait_idle();
      check_log("fairness", '{2, 3, 0});

      // withdraw: 0 raises and drops its request while 1 is being served
      tb_data[1] = 8'd12;
      tb_valid   = 4'b0010;
      drive();
      wait_accept(1);
      repeat (2) tick();
      tb_data[0]  = 8'd77;
      tb_valid[0] = 1'b1;
      drive();
      repeat (4) tick();
      tb_valid[0] = 1'b0;
      drive();
      wait_idle();
      check_log("withdraw", '{1});

      // reset four cycles after accepting requester 3
      tb_data[3] = 8'd200;
      tb_valid   = 4'b1000;
      drive();
      wait_accept(3);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("mid_rst_res_valid", 32'(res_valid), 0);
      check("mid_rst_res_id", 32'(res_id), 0);
      check("mid_rst_res_data", 32'(res_data), 0);
      check("mid_rst_busy", 32'(busy), 0);
      rst = 1'b0;
      repeat (12) tick();
      check_log("rst_abort", '{3});
      tb_data[0] = 8'd6; tb_data[2] = 8'd250;
      tb_valid   = 4'b0101;
      drive();
      wait_idle();
      check_log("after_rst", '{0, 2});

      // randomized traffic with occasional withdrawals and extreme operands
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!tb_valid[i] && $urandom_range(0, 99) < 15) begin
               r = $urandom_range(0, 9);
               tb_data[i]  = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : W'($urandom);
               tb_valid[i] = 1'b1;
            end else if (tb_valid[i] && $urandom_range(0, 99) < 3) begin
               tb_valid[i] = 1'b0;
            end
         end
         drive();
         tick();
      end
      wait_idle();
      grant_log.delete();
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
